// File: rtl/maxnet_sequencer.sv
// Control sequencer for a Maxnet competitive-inhibition datapath.
// It runs one shared update unit over every neuron in turn, then commits, until at most one neuron remains nonzero.
module maxnet_sequencer #(
  parameter  int N        = 4,
  parameter  int MAX_ITER = 15,
  parameter  int ITER_W   = 4,
  localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      nz,
  output logic              ld_x,
  output logic [SEL_W-1:0]  sel,
  output logic              calc_en,
  output logic              commit,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      winner,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CHECK  = 3'd2,
    S_CALC   = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N - 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  state_t              state_q, state_d;
  logic                start_q;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [N-1:0]        winner_q, winner_d;
  logic                no_winner_q, no_winner_d;
  logic                timeout_q, timeout_d;

  logic                trigger;
  logic                at_most_one;
  logic                cap_hit;

  assign trigger     = start & ~start_q;
  // Clearing the lowest set bit leaves zero exactly when popcount(nz) <= 1.
  assign at_most_one = ((nz & (nz - N'(1))) == '0);
  assign cap_hit     = (iter_q == ITER_CAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      sel_q       <= '0;
      iter_q      <= '0;
      winner_q    <= '0;
      no_winner_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      sel_q       <= sel_d;
      iter_q      <= iter_d;
      winner_q    <= winner_d;
      no_winner_q <= no_winner_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (trigger) state_d = S_LOAD;
      S_LOAD:   state_d = S_CHECK;
      S_CHECK: begin
        if (at_most_one || cap_hit) state_d = S_DONE;
        else                        state_d = S_CALC;
      end
      S_CALC:   if (sel_q == SEL_LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_CHECK;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Run registers: result fields clear on entry to LOAD, so they read 0 for the whole new run.
  always_comb begin
    sel_d       = sel_q;
    iter_d      = iter_q;
    winner_d    = winner_q;
    no_winner_d = no_winner_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          iter_d      = '0;
          winner_d    = '0;
          no_winner_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (at_most_one || cap_hit) begin
          winner_d    = nz;
          no_winner_d = (nz == '0);
          timeout_d   = ~at_most_one;
        end else begin
          sel_d = '0;
        end
      end
      S_CALC: begin
        if (sel_q != SEL_LAST) sel_d = sel_q + SEL_W'(1);
      end
      S_COMMIT: begin
        if (!cap_hit) iter_d = iter_q + ITER_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_x    = 1'b0;
    calc_en = 1'b0;
    commit  = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE:   busy    = 1'b0;
      S_LOAD:   ld_x    = 1'b1;
      S_CALC:   calc_en = 1'b1;
      S_COMMIT: commit  = 1'b1;
      S_DONE:   done    = 1'b1;
      default:  ;
    endcase
  end

  assign sel        = sel_q;
  assign iter_count = iter_q;
  assign winner     = winner_q;
  assign no_winner  = no_winner_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Directed bench for maxnet_sequencer: a tiny nz model advances per commit, a scoreboard holds per-run results.
module tb_maxnet_sequencer;
  localparam int N = 4;
  localparam int MAX_ITER = 15;
  localparam int ITER_W = 4;
  localparam int SEL_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N-1:0]      nz;
  logic              ld_x, calc_en, commit, busy, done, no_winner, timeout;
  logic [SEL_W-1:0]  sel;
  logic [N-1:0]      winner;
  logic [ITER_W-1:0] iter_count;

  maxnet_sequencer #(.N(N), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .nz(nz),
    .ld_x(ld_x), .sel(sel), .calc_en(calc_en), .commit(commit),
    .busy(busy), .done(done), .winner(winner), .no_winner(no_winner),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // nz the datapath would show after a given number of commits in the current run
  logic [N-1:0] nz_tab [0:15];
  int ncm_dp = 0;
  assign nz = nz_tab[ncm_dp[3:0]];
  always @(posedge clk) begin
    if (ld_x) ncm_dp <= 0;
    else if (commit && ncm_dp < 15) ncm_dp <= ncm_dp + 1;
  end

  typedef struct {
    logic [N-1:0]      winner;
    logic              no_winner;
    logic              timeout;
    logic [ITER_W-1:0] iter;
    int                done_t;
    int                commits;
    int                calcs;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tab(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    nz_tab[0] = a;
    nz_tab[1] = b;
    for (int i = 2; i < 16; i++) nz_tab[i] = c;
  endtask

  function automatic exp_t mk(input logic [N-1:0] w, input logic nw, input logic to,
                              input int it, input int k);
    exp_t e;
    e.winner = w; e.no_winner = nw; e.timeout = to; e.iter = ITER_W'(it);
    e.done_t = 3 + k * (N + 2);
    e.commits = k; e.calcs = k * N;
    return e;
  endfunction

  // Called just after a negedge; t counts negedges after E0, so done is expected at t = 3 + k*(N+2).
  task automatic run(input string name, input int hold, input int pulse_at, input exp_t e);
    int t = 0, got_t = 0, nld = 0, ncm = 0, ncalc = 0, ndone = 0;
    bit got = 0;
    exp_t x;
    sb.push_back(e);
    start = 1'b1;
    while (t < e.done_t + hold + 20) begin
      @(negedge clk);
      t++;
      if (t == hold) start = 1'b0;
      if (pulse_at > 0 && t == pulse_at) start = 1'b1;
      if (pulse_at > 0 && t == pulse_at + 1) start = 1'b0;
      if (t == 2) begin
        chk({name, ".iter_clr"}, iter_count, 0);
        chk({name, ".winner_clr"}, winner, 0);
        chk({name, ".timeout_clr"}, timeout, 0);
      end
      if (ld_x) nld++;
      if (commit) ncm++;
      if (calc_en) begin
        chk({name, ".sel"}, sel, ncalc % N);
        ncalc++;
      end
      if (done) begin
        ndone++;
        if (!got) begin
          got = 1; got_t = t;
          x = sb.pop_front();
          chk({name, ".done_t"}, t, x.done_t);
          chk({name, ".busy_done"}, busy, 1);
          chk({name, ".winner"}, winner, x.winner);
          chk({name, ".no_winner"}, no_winner, x.no_winner);
          chk({name, ".timeout"}, timeout, x.timeout);
          chk({name, ".iter"}, iter_count, x.iter);
          chk({name, ".ld_x_pulses"}, nld, 1);
          chk({name, ".commits"}, ncm, x.commits);
          chk({name, ".calcs"}, ncalc, x.calcs);
        end
      end
      if (got && t == got_t + 1) chk({name, ".busy_after"}, busy, 0);
      if (got && t >= got_t + 2 && t >= hold + 1) break;
    end
    start = 1'b0;
    chk({name, ".done_seen"}, got, 1);
    chk({name, ".done_pulses"}, ndone, 1);
    if (got) chk({name, ".winner_held"}, winner, x.winner);
    $display("run %s: done at t=%0d winner=%b iter=%0d timeout=%b no_winner=%b",
             name, got_t, winner, iter_count, timeout, no_winner);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    set_tab(4'b1111, 4'b1111, 4'b1111);
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.sel", sel, 0);
    chk("rst.winner", winner, 0);
    chk("rst.iter", iter_count, 0);
    chk("rst.pulses", {ld_x, calc_en, commit, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    set_tab(4'b1111, 4'b0110, 4'b0010);
    run("normal", 2, 4, mk(4'b0010, 0, 0, 2, 2));
    set_tab(4'b0100, 4'b0100, 4'b0100);
    run("immediate", 2, 0, mk(4'b0100, 0, 0, 0, 0));
    set_tab(4'b1111, 4'b1111, 4'b1111);
    run("cap", 2, 0, mk(4'b1111, 0, 1, 15, 15));
    set_tab(4'b1111, 4'b0000, 4'b0000);
    run("suppressed", 2, 0, mk(4'b0000, 1, 0, 1, 1));
    set_tab(4'b1111, 4'b0110, 4'b0010);
    run("held20", 20, 0, mk(4'b0010, 0, 0, 2, 2));
    set_tab(4'b1000, 4'b1000, 4'b1000);
    run("fresh", 2, 0, mk(4'b1000, 0, 0, 0, 0));

    // Abort mid-CALC with an asynchronous reset between edges.
    set_tab(4'b1111, 4'b0110, 4'b0010);
    start = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (t == 2) start = 1'b0;
    end
    chk("abort.sel_before", sel, 2);
    chk("abort.calc_before", calc_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.sel", sel, 0);
    chk("abort.pulses", {ld_x, calc_en, commit, done}, 0);
    chk("abort.winner", winner, 0);
    chk("abort.iter", iter_count, 0);
    @(posedge clk);
    #1;
    chk("abort.hold_busy", busy, 0);
    chk("abort.hold_done", done, 0);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run("after_reset", 2, 0, mk(4'b0010, 0, 0, 2, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/maxnet_sequencer.md
Name: maxnet_sequencer

Overview:
- Control FSM for a Maxnet competitive-inhibition datapath with N neurons.
- Time-multiplexes one shared "x_i − ε·Σx_j, ReLU" update unit across all neurons: selects each neuron in turn, then commits the new vector.
- Monitors the datapath's per-neuron nonzero flags and stops when at most one neuron is nonzero or an iteration cap is reached.
- Sits between the top-level start/done interface and the register file and update unit of the Maxnet datapath.

Parameters:
N, 4, number of neurons (N ≥ 2)
MAX_ITER, 15, iteration cap before forced termination
ITER_W, 4, width of the iteration counter; must hold MAX_ITER
SEL_W, $clog2(N), width of the neuron select (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level request; a run begins on its rising edge
nz  in  N  per-neuron nonzero flags from the datapath registers (bit i = neuron i ≠ 0)
ld_x  out  1  one-cycle pulse: datapath loads initial X inputs
sel  out  SEL_W  neuron index presented to the shared update unit
calc_en  out  1  shared unit result for neuron sel is written to the shadow register
commit  out  1  one-cycle pulse: shadow registers copied to working registers
busy  out  1  high from LOAD through DONE inclusive
done  out  1  one-cycle completion pulse
winner  out  N  nz snapshot captured on entry to DONE; held until next LOAD
no_winner  out  1  winner == 0 (all neurons suppressed); held with winner
timeout  out  1  run ended by the iteration cap; held with winner
iter_count  out  ITER_W  commits in the current/last run; cleared at LOAD

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; start_q=0; all outputs 0 (sel=0, winner=0, iter_count=0). Release takes effect on the next clk edge.
- Start edge detect: start_q registers start. A trigger is start=1 & start_q=0 while in IDLE. A start held high gives exactly one run. Edges while busy are ignored. start=1 at reset release counts as an edge.
- IDLE: outputs quiescent. On trigger → LOAD.
- LOAD (1 cycle): ld_x=1; iter_count←0; winner, no_winner, timeout←0 → CHECK.
- CHECK (1 cycle): nz sampled here, valid for the registers loaded/committed at the previous edge.
  - popcount(nz) ≤ 1 → DONE.
  - else if iter_count == MAX_ITER → DONE with timeout←1.
  - else → CALC, with sel←0.
- CALC (N cycles): calc_en=1 each cycle; sel = 0,1,…,N−1 on consecutive cycles; working registers unchanged. After sel=N−1 → COMMIT; sel holds N−1.
- COMMIT (1 cycle): commit=1; iter_count+1 (saturates at MAX_ITER) → CHECK.
- DONE (1 cycle): done=1; winner←nz; no_winner←(nz==0) → IDLE. busy drops in the following cycle.
- Decoded outputs (ld_x, calc_en, commit, done, busy) are Moore outputs of the state register.
- Timing: edge E0 samples the trigger. Zero-iteration runs assert done in the cycle after E2. Each iteration adds N+2 cycles, so done is high in the cycle after E(2 + k·(N+2)) for k iterations. For N=4: 6 cycles per iteration.
- Ties: if all equal-valued neurons reach zero together, nz=0 at CHECK → DONE, no_winner=1, timeout=0.
- Reset mid-run: any state aborts immediately to IDLE with all outputs 0. No done pulse for the aborted run.
- sel never exceeds N−1; no X/Z outputs after reset.

Test Plan:
- Normal run: N=4, start high 2 cycles; nz=1111 at CHECK 1, 0110 at CHECK 2, 0010 at CHECK 3. Expect: ld_x one pulse; sel sequence 0,1,2,3 twice; two commit pulses; done single pulse after E14; winner=0010, iter_count=2, timeout=0, no_winner=0.
- Immediate winner: nz=0100 at first CHECK. Expect: done after E2; no calc_en or commit; iter_count=0; winner=0100.
- Cap: nz stuck at 1111. Expect: 15 commits; done after E(2+15·6)=E92; timeout=1, winner=1111, iter_count=15.
- All suppressed: nz=1111 then 0000. Expect: done after E8; no_winner=1, winner=0, iter_count=1, timeout=0.
- Start handling: start held high 20 cycles → exactly one done. A second start pulse during CALC is ignored. A fresh low→high after done starts a new run with iter_count cleared at LOAD.
- Async reset: drop rst mid-CALC (sel=2) between clock edges. Expect: all outputs 0 immediately, no done. After release, a new start edge gives a normal run.
